// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Optional build macro used by bus_arbiter: BUS_ARB_CONTENTION_EN.
package bus_pkg;

    // Supported range for the number of requesting lanes.
    localparam int MIN_LANES = 2;
    localparam int MAX_LANES = 16;

    // Arbiter ownership state: nobody on the bus, or exactly one owner.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } bus_state_e;

    // Width of a binary lane index (never narrower than one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when a lane count lies inside the supported range.
    function automatic bit lanes_legal(input int n);
        return (n >= MIN_LANES) && (n <= MAX_LANES);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: starting one past i_ptr and wrapping
// modulo LANES, returns the first lane whose request is high and whose
// exclude bit is clear.
module rr_pick
    import bus_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int IW    = idx_w(LANES)
) (
    input  logic [LANES-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    input  logic [LANES-1:0] i_excl,
    output logic             o_found,
    output logic [LANES-1:0] o_onehot,
    output logic [IW-1:0]    o_index
);

    logic [LANES-1:0] w_cand;
    logic [IW-1:0]    w_j;

    assign w_cand = i_req & ~i_excl;

    // Walk ptr+1, ptr+2, ... and latch the first eligible lane.
    always_comb begin
        o_found  = 1'b0;
        o_onehot = '0;
        o_index  = '0;
        w_j      = '0;
        for (int k = 1; k <= LANES; k++) begin
            w_j = IW'((int'(i_ptr) + k) % LANES);
            if (!o_found && w_cand[w_j]) begin
                o_found      = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_index      = w_j;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for a shared WIDTH-bit bus.
// One lane is granted per cycle; its data, a valid flag and its index are
// registered onto the bus. With HOLD=1 the owner keeps the bus while it
// requests, up to HOLD_MAX cycles when someone else is waiting.
// Optional build macro: BUS_ARB_CONTENTION_EN adds a 16-bit saturating
// count of cycles in which some requesting lane was left ungranted.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int LANES    = 4,
    parameter  int HOLD     = 1,
    parameter  int HOLD_MAX = 4,
    localparam int IW       = idx_w(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       lane_req,
    input  logic [LANES*WIDTH-1:0] lane_data,
    output logic [LANES-1:0]       lane_grant,
    output logic [WIDTH-1:0]       bus_data,
    output logic                   bus_valid,
    output logic [IW-1:0]          bus_owner,
    output bus_state_e             dbg_state
`ifdef BUS_ARB_CONTENTION_EN
    ,
    output logic [15:0]            contention_cnt
`endif
);

    // Handshake: no ready path. A lane requests by holding lane_req high;
    // it owns the bus for a cycle when lane_grant/bus_valid show it after
    // the sampling edge, and lane_data is taken at that same edge.

    localparam bit LANES_OK = lanes_legal(LANES);
    localparam int CW       = $clog2(HOLD_MAX + 2);
    localparam logic [CW-1:0] LIMIT = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;
    localparam logic [CW-1:0] SAT   = CW'(HOLD_MAX);

    bus_state_e       r_state;
    logic [LANES-1:0] r_grant;
    logic [WIDTH-1:0] r_data;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [CW-1:0]    r_hold_cnt;

    bus_state_e       w_state_nxt;
    logic [LANES-1:0] w_grant_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic [IW-1:0]    w_owner_nxt;
    logic [IW-1:0]    w_ptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    logic [LANES-1:0] w_req;
    logic             w_owner_req;
    logic             w_others;
    logic             w_at_limit;
    logic             w_keep;
    logic             w_force;
    logic [LANES-1:0] w_excl;
    logic             w_found;
    logic [LANES-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_index;

    // An out-of-range lane count never grants anything.
    assign w_req       = LANES_OK ? lane_req : '0;
    assign w_owner_req = |(w_req & r_grant);
    assign w_others    = |(w_req & ~r_grant);
    // >= rather than == so a saturated counter still yields to a late contender.
    assign w_at_limit  = (HOLD_MAX > 0) && (r_hold_cnt >= LIMIT) && w_others;
    assign w_keep      = (r_state == OWNED) && (HOLD != 0) && w_owner_req && !w_at_limit;
    assign w_force     = (r_state == OWNED) && (HOLD != 0) && w_owner_req && w_at_limit;
    assign w_excl      = w_force ? r_grant : '0;

    rr_pick #(
        .LANES (LANES)
    ) u_pick (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .i_excl   (w_excl),
        .o_found  (w_found),
        .o_onehot (w_pick_onehot),
        .o_index  (w_pick_index)
    );

    // Next-state: keep the owner, re-arbitrate without a bubble, or go idle.
    always_comb begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = '0;
        if (w_keep) begin
            w_state_nxt = OWNED;
            w_grant_nxt = r_grant;
            w_owner_nxt = r_owner;
            w_cnt_nxt   = (r_hold_cnt >= SAT) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end else if (w_found) begin
            w_state_nxt = OWNED;
            w_grant_nxt = w_pick_onehot;
            w_owner_nxt = w_pick_index;
            w_ptr_nxt   = w_pick_index;
        end
    end

    // Winner's data as sampled at the same edge; zero when nobody wins.
    always_comb begin
        w_data_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_grant_nxt[i]) begin
                w_data_nxt = lane_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State, grant, bus and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_data     <= '0;
            r_owner    <= '0;
            r_ptr      <= IW'(LANES - 1);
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_data     <= w_data_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_cnt_nxt;
        end
    end

    assign lane_grant = r_grant;
    assign bus_data   = r_data;
    assign bus_valid  = (r_state == OWNED);
    assign bus_owner  = r_owner;
    assign dbg_state  = r_state;

`ifdef BUS_ARB_CONTENTION_EN
    logic [15:0] r_cont;

    // Count cycles where a requesting lane is left without the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cont <= '0;
        end else if ((|(w_req & ~w_grant_nxt)) && (r_cont != 16'hFFFF)) begin
            r_cont <= r_cont + 16'd1;
        end
    end

    assign contention_cnt = r_cont;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a HOLD=0 and a HOLD=1 (HOLD_MAX=4) instance share
// stimulus; a behavioural model predicts every registered output.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int HMAX  = 4;
    localparam int IW    = $clog2(LANES);
    localparam int EW    = 1 + IW + LANES + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [LANES-1:0]       lane_req = '0;
    logic [LANES*WIDTH-1:0] lane_data = '0;

    logic [LANES-1:0] g_n, g_h;
    logic [WIDTH-1:0] d_n, d_h;
    logic             v_n, v_h;
    logic [IW-1:0]    o_n, o_h;
    bus_state_e       s_n, s_h;
`ifdef BUS_ARB_CONTENTION_EN
    logic [15:0]      c_n, c_h;
    int               m_cont[2];
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    int m_owner[2];
    int m_run[2];
    int m_last[2];

    bus_arbiter #(.WIDTH(WIDTH), .LANES(LANES), .HOLD(0), .HOLD_MAX(HMAX)) dut_n (
        .clk(clk), .rst_n(rst_n), .lane_req(lane_req), .lane_data(lane_data),
        .lane_grant(g_n), .bus_data(d_n), .bus_valid(v_n), .bus_owner(o_n),
        .dbg_state(s_n)
`ifdef BUS_ARB_CONTENTION_EN
        , .contention_cnt(c_n)
`endif
    );

    bus_arbiter #(.WIDTH(WIDTH), .LANES(LANES), .HOLD(1), .HOLD_MAX(HMAX)) dut_h (
        .clk(clk), .rst_n(rst_n), .lane_req(lane_req), .lane_data(lane_data),
        .lane_grant(g_h), .bus_data(d_h), .bus_valid(v_h), .bus_owner(o_h),
        .dbg_state(s_h)
`ifdef BUS_ARB_CONTENTION_EN
        , .contention_cnt(c_h)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // First requesting lane after 'after' (wrapping), skipping lane 'skip'.
    function automatic int rr_first(input logic [LANES-1:0] req, input int after, input int skip);
        for (int k = 1; k <= LANES; k++) begin
            int j;
            j = (after + k) % LANES;
            if (req[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_run[m]   = 0;
            m_last[m]  = LANES - 1;
`ifdef BUS_ARB_CONTENTION_EN
            m_cont[m]  = 0;
`endif
        end
        exp_q.delete();
    endtask

    // Advance one clock of the reference for mode m (0: no hold, 1: hold).
    task automatic model_step(input int m, input logic [LANES-1:0] req,
                              input logic [LANES*WIDTH-1:0] data);
        int own;
        int win;
        bit others;
        bit owner_req;
        logic [LANES-1:0] omask;
        logic [LANES-1:0] gexp;
        logic [WIDTH-1:0] dexp;
        own = m_owner[m];
        omask = '0;
        if (own >= 0) omask[own] = 1'b1;
        others = (req & ~omask) != '0;
        owner_req = (own >= 0) && req[own];
        if (m == 1 && owner_req && !(m_run[m] >= HMAX && others)) begin
            win = own;
            m_run[m]++;
        end else begin
            if (m == 1 && owner_req) win = rr_first(req, m_last[m], own);
            else                     win = rr_first(req, m_last[m], -1);
            if (win < 0) begin
                m_run[m] = 0;
            end else begin
                m_last[m] = win;
                m_run[m]  = 1;
            end
        end
        m_owner[m] = win;
        gexp = '0;
        dexp = '0;
        if (win >= 0) begin
            gexp[win] = 1'b1;
            dexp = data[win*WIDTH +: WIDTH];
        end
`ifdef BUS_ARB_CONTENTION_EN
        if ((req & ~gexp) != '0 && m_cont[m] < 16'hFFFF) m_cont[m]++;
`endif
        exp_q.push_back({(win >= 0), IW'((win >= 0) ? win : 0), gexp, dexp});
    endtask

    task automatic check_dut(input int m);
        logic [EW-1:0] e;
        string p;
        e = exp_q.pop_front();
        p = (m == 0) ? "h0" : "h1";
        check({p, ".valid"}, 32'((m == 0) ? v_n : v_h), 32'(e[EW-1]));
        check({p, ".owner"}, 32'((m == 0) ? o_n : o_h), 32'(e[EW-2 -: IW]));
        check({p, ".grant"}, 32'((m == 0) ? g_n : g_h), 32'(e[LANES+WIDTH-1 -: LANES]));
        check({p, ".data"},  32'((m == 0) ? d_n : d_h), 32'(e[WIDTH-1:0]));
        check({p, ".state"}, 32'((m == 0) ? s_n : s_h), 32'(e[EW-1]));
`ifdef BUS_ARB_CONTENTION_EN
        check({p, ".cont"},  32'((m == 0) ? c_n : c_h), 32'(m_cont[m]));
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".h0.grant"}, 32'(g_n), 32'd0);
        check({tag, ".h0.data"},  32'(d_n), 32'd0);
        check({tag, ".h0.valid"}, 32'(v_n), 32'd0);
        check({tag, ".h0.owner"}, 32'(o_n), 32'd0);
        check({tag, ".h1.grant"}, 32'(g_h), 32'd0);
        check({tag, ".h1.data"},  32'(d_h), 32'd0);
        check({tag, ".h1.valid"}, 32'(v_h), 32'd0);
        check({tag, ".h1.owner"}, 32'(o_h), 32'd0);
`ifdef BUS_ARB_CONTENTION_EN
        check({tag, ".h0.cont"},  32'(c_n), 32'd0);
        check({tag, ".h1.cont"},  32'(c_h), 32'd0);
`endif
    endtask

    // Driver: apply inputs, predict, clock, compare 1 ns after the edge.
    task automatic step(input logic [LANES-1:0] req, input logic [LANES*WIDTH-1:0] data);
        lane_req  = req;
        lane_data = data;
        model_step(0, req, data);
        model_step(1, req, data);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    // Asynchronous reset mid-cycle, released on a falling edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [LANES*WIDTH-1:0] rand_data();
        logic [LANES*WIDTH-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        logic [LANES-1:0] r;
        model_reset();

        // Reset held with every lane requesting.
        lane_req  = 4'b1111;
        lane_data = rand_data();
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, lane_data);
        check("first.grant", 32'(g_h), 32'h1);

        // Two contenders, lanes 0 and 2.
        for (int i = 0; i < 8; i++) step(4'b0101, {8'h00, 8'hC2, 8'h00, 8'hA0});

        // Lanes 1 and 3 contending for a long stretch.
        for (int i = 0; i < 20; i++) step(4'b1010, rand_data());

        // Lane 2 alone with incrementing data.
        for (int i = 0; i < 20; i++) step(4'b0100, {8'h00, 8'(i), 8'h00, 8'h00});

        // Owner lane 0 drops while lane 3 waits.
        step(4'b0001, rand_data());
        step(4'b1001, rand_data());
        step(4'b1000, rand_data());
        check("handoff.owner", 32'(o_h), 32'd3);

        // Reset during lane 2 ownership, then lanes 2 and 3 request.
        for (int i = 0; i < 3; i++) step(4'b0100, rand_data());
        pulse_reset();
        step(4'b1100, rand_data());
        check("rerst.grant", 32'(g_h), 32'h4);

        // Randomized traffic with occasional resets.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) r = LANES'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) pulse_reset();
            step(r, rand_data());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
